// File: rtl/cve2_alu_arbiter.sv
// Shares one ALU between EX and MD: grant is same-cycle, response registered 1 cycle later.
// No response backpressure; EX is stalled while MD holds a lock, bounded by LockMax.
module cve2_alu_arbiter #(
    parameter int unsigned LockMax = 34,
    parameter int unsigned OpW     = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            ex_req_i,
    input  logic [OpW-1:0]  ex_op_i,
    input  logic [31:0]     ex_a_i,
    input  logic [31:0]     ex_b_i,
    output logic            ex_gnt_o,
    output logic            ex_rvalid_o,
    output logic [31:0]     ex_rdata_o,
    output logic            ex_cmp_o,

    input  logic            md_req_i,
    input  logic            md_lock_i,
    input  logic [OpW-1:0]  md_op_i,
    input  logic [32:0]     md_a_i,
    input  logic [32:0]     md_b_i,
    output logic            md_gnt_o,
    output logic            md_rvalid_o,
    output logic [33:0]     md_rdata_o,

    output logic [OpW-1:0]  alu_operator_o,
    output logic [31:0]     alu_operand_a_o,
    output logic [31:0]     alu_operand_b_o,
    output logic [32:0]     alu_multdiv_a_o,
    output logic [32:0]     alu_multdiv_b_o,
    output logic            alu_multdiv_sel_o,
    output logic            alu_first_cycle_o,
    input  logic [31:0]     alu_result_i,
    input  logic [33:0]     alu_adder_ext_i,
    input  logic            alu_cmp_i,

    output logic            lock_err_o,
    output logic            busy_o
);

    localparam logic [OpW-1:0] ALU_ADD  = '0;
    localparam logic [5:0]     LOCK_MAX = 6'(LockMax);
    localparam logic [5:0]     CNT_SAT  = 6'h3f;

    typedef enum logic [1:0] {
        IDLE,
        EX_OWN,
        MD_OWN,
        MD_LOCK
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        last_md_q;
    logic [5:0]  lock_cnt_q;
    logic        lock_err_q;
    logic        prev_ex_q;
    logic        prev_md_q;
    logic        ex_rvalid_q;
    logic        md_rvalid_q;
    logic [31:0] ex_rdata_q;
    logic        ex_cmp_q;
    logic [33:0] md_rdata_q;

    logic        in_lock;
    logic        lock_ovr;
    logic        lock_hold;
    logic        md_lock_eff;
    logic        ex_gnt;
    logic        md_gnt;

    assign in_lock = (state_q == MD_LOCK);

    // A lock that has run LockMax grants while EX waits is broken; MD dropping
    // its request is a voluntary release and falls back to round-robin.
    assign lock_ovr    = in_lock && md_req_i && ex_req_i && (lock_cnt_q >= LOCK_MAX);
    assign lock_hold   = in_lock && md_req_i && !lock_ovr;
    assign md_lock_eff = md_lock_i && !lock_ovr;

    always_comb begin
        ex_gnt = 1'b0;
        md_gnt = 1'b0;
        if (!rst_ni) begin
            ex_gnt = 1'b0;
            md_gnt = 1'b0;
        end else if (lock_hold) begin
            md_gnt = 1'b1;
        end else if (ex_req_i && md_req_i) begin
            ex_gnt = last_md_q;
            md_gnt = !last_md_q;
        end else begin
            ex_gnt = ex_req_i;
            md_gnt = md_req_i;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (ex_gnt) begin
            state_d = EX_OWN;
        end else if (md_gnt) begin
            state_d = md_lock_eff ? MD_LOCK : MD_OWN;
        end
    end

    always_comb begin
        alu_operator_o  = ALU_ADD;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        alu_multdiv_a_o = '0;
        alu_multdiv_b_o = '0;
        if (ex_gnt) begin
            alu_operator_o  = ex_op_i;
            alu_operand_a_o = ex_a_i;
            alu_operand_b_o = ex_b_i;
        end else if (md_gnt) begin
            alu_operator_o  = md_op_i;
            alu_multdiv_a_o = md_a_i;
            alu_multdiv_b_o = md_b_i;
        end
    end

    assign alu_multdiv_sel_o = md_gnt;
    assign alu_first_cycle_o = (ex_gnt && !prev_ex_q) || (md_gnt && !prev_md_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_md_q   <= 1'b1;
            lock_cnt_q  <= '0;
            lock_err_q  <= 1'b0;
            prev_ex_q   <= 1'b0;
            prev_md_q   <= 1'b0;
            ex_rvalid_q <= 1'b0;
            md_rvalid_q <= 1'b0;
            ex_rdata_q  <= '0;
            ex_cmp_q    <= 1'b0;
            md_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ex_gnt || md_gnt) begin
                last_md_q <= md_gnt;
            end
            // Counts grants that keep MD in the lock, including the one entering it.
            if (md_gnt && md_lock_eff) begin
                lock_cnt_q <= (lock_cnt_q == CNT_SAT) ? lock_cnt_q : lock_cnt_q + 6'd1;
            end else begin
                lock_cnt_q <= '0;
            end
            lock_err_q  <= lock_err_q | lock_ovr;
            prev_ex_q   <= ex_gnt;
            prev_md_q   <= md_gnt;
            ex_rvalid_q <= ex_gnt;
            md_rvalid_q <= md_gnt;
            if (ex_gnt) begin
                ex_rdata_q <= alu_result_i;
                ex_cmp_q   <= alu_cmp_i;
            end
            if (md_gnt) begin
                md_rdata_q <= alu_adder_ext_i;
            end
        end
    end

    assign ex_gnt_o    = ex_gnt;
    assign md_gnt_o    = md_gnt;
    assign ex_rvalid_o = ex_rvalid_q;
    assign ex_rdata_o  = ex_rdata_q;
    assign ex_cmp_o    = ex_cmp_q;
    assign md_rvalid_o = md_rvalid_q;
    assign md_rdata_o  = md_rdata_q;
    assign lock_err_o  = lock_err_q;
    assign busy_o      = in_lock | ex_rvalid_q | md_rvalid_q;

endmodule

// File: doc/cve2_alu_arbiter.md
# cve2_alu_arbiter

Sequencing arbiter sharing the single `cve2_alu` instance between the execute path (EX, 32-bit operands) and the multiply/divide unit (MD, 33-bit operands, multi-cycle sequences). One ALU operation is granted per cycle. The ALU is driven combinationally from the grant, and its result is registered back to the granted requester one cycle later. It sits between the ID/EX stage, `cve2_multdiv_*` and `cve2_alu`, and owns `multdiv_sel` and `instr_first_cycle`.

## Interface
Parameters:
- LockMax, 34: maximum consecutive locked MD grants before the lock is overridden (covers 33-cycle divide plus setup).
- OpW, 7: width of `alu_op_e` encoding.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- ex_req_i  in  1  EX requests an ALU op this cycle.
- ex_op_i  in  OpW  EX operator.
- ex_a_i, ex_b_i  in  32  EX operands.
- ex_gnt_o  out  1  EX op issued this cycle.
- ex_rvalid_o  out  1  EX response valid (one cycle after grant).
- ex_rdata_o  out  32  registered `result`.
- ex_cmp_o  out  1  registered `comparison_result`.
- md_req_i  in  1  MD requests an ALU op.
- md_lock_i  in  1  MD holds ownership after this grant.
- md_op_i  in  OpW  MD operator.
- md_a_i, md_b_i  in  33  MD operands.
- md_gnt_o  out  1  MD op issued this cycle.
- md_rvalid_o  out  1  MD response valid.
- md_rdata_o  out  34  registered `adder_result_ext`.
- alu_operator_o  out  OpW  to ALU.
- alu_operand_a_o, alu_operand_b_o  out  32  to ALU.
- alu_multdiv_a_o, alu_multdiv_b_o  out  33  to ALU.
- alu_multdiv_sel_o  out  1  1 when MD granted.
- alu_first_cycle_o  out  1  to ALU `instr_first_cycle`.
- alu_result_i  in  32, alu_adder_ext_i  in  34, alu_cmp_i  in  1  from ALU.
- lock_err_o  out  1  sticky: lock exceeded LockMax.
- busy_o  out  1  MD lock held or response pending.

## Operation
- States: IDLE, EX_OWN, MD_OWN, MD_LOCK. Reset -> IDLE.
- Grant is combinational from request and state; at most one of ex_gnt_o/md_gnt_o is high.
- IDLE/EX_OWN/MD_OWN: round-robin. On a tie, the requester not granted last wins. `last_md` flop resets to 1, so EX wins the first tie after reset.
- A grant moves the state to EX_OWN or MD_OWN. With no request, the state moves to IDLE.
- An MD grant with md_lock_i=1 enters or stays in MD_LOCK.
- MD_LOCK: only MD can be granted. EX is stalled even when requesting. The state exits to round-robin on an MD grant with md_lock_i=0, or if md_req_i=0. Dropping the request is a lock release.
- lock_cnt (6-bit) counts consecutive MD_LOCK grants and clears on leaving MD_LOCK.
  - When lock_cnt reaches LockMax with ex_req_i=1, md_lock_i is ignored for arbitration and lock_err_o sets. lock_err_o clears only on reset.
  - EX is then granted via round-robin.
- ALU drive:
  - operator and operands come from the granted requester.
  - multdiv_sel_o = md_gnt_o.
  - Unused operand ports are driven to 0.
  - With no grant, the ALU sees operator=ALU_ADD and all operands 0.
- alu_first_cycle_o = 1 on a grant whose requester differs from the previous cycle's grantee, or when the previous cycle had no grant. For example, within an MD_LOCK sequence it is 1 only on the first grant.
- Response: on grant, the corresponding rdata/cmp registers capture the ALU outputs and rvalid goes high next cycle for exactly one cycle. The registers hold their value otherwise.

## Timing
- Request to grant: 0 cycles (same cycle). Grant to rvalid/rdata: 1 cycle. Back-to-back grants give rvalid every cycle.
- Reset values:
  - ex_gnt_o, md_gnt_o, ex_rvalid_o, md_rvalid_o, lock_err_o, busy_o = 0.
  - ex_rdata_o, ex_cmp_o, md_rdata_o = 0.
  - ALU drive = ALU_ADD with operands 0; alu_multdiv_sel_o = 0; alu_first_cycle_o = 0.
- Reset mid-lock: the state returns to IDLE immediately, lock_cnt=0, and pending rvalid is dropped.
- Requesters must hold op/operands stable only in the grant cycle. A request withdrawn without grant has no effect.
- busy_o = (state==MD_LOCK) | ex_rvalid pending | md_rvalid pending (registered).

## Test plan
- After reset, ex_req=md_req=1 both held -> grants alternate EX, MD, EX…; first grant EX; alu_first_cycle_o=1 on every grant.
- EX ADD a=5, b=7 -> ex_gnt same cycle; next cycle ex_rvalid=1, ex_rdata=12, ex_cmp per ALU; md_rvalid stays 0.
- MD lock for 33 grants with ex_req=1 throughout -> ex_gnt=0 for all 33, alu_multdiv_sel_o=1, alu_first_cycle_o=1 only on grant 1. The grant with lock=0 is followed by an EX grant.
- MD holds lock=1 for 40 cycles with ex_req=1, LockMax=34 -> EX granted after the 34th locked grant, lock_err_o=1 and sticky.
- Reset asserted while in MD_LOCK with an rvalid pending -> all outputs 0 asynchronously. After release, an EX request is granted in the first cycle.
- Idle (no requests) -> ALU operator ALU_ADD, operands 0, busy_o=0, no rvalid.
